// File: rtl/decoder_3x8_pulse_pkg.sv
// Shared types and helpers for the registered N-to-2**N pulse decoder.
package dec_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        RECOVER = 2'd2
    } dec_state_e;

    localparam int DEC_N    = 3;
    // Widest code the decoder supports; onehot() is sized for it and sliced by the user.
    localparam int DEC_NMAX = 4;

    function automatic logic [2**DEC_NMAX-1:0] onehot(input logic [DEC_NMAX-1:0] code);
        logic [2**DEC_NMAX-1:0] r;
        r       = '0;
        r[code] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/decoder_3x8_pulse_hold_counter.sv
// Down-counter that times the ACTIVE hold; zero flags the last hold cycle.
module hold_counter #(
    parameter int HOLD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    input  logic clr,
    output logic zero
);

    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     cnt <= '0;
        else if (clr)                cnt <= '0;
        else if (load)               cnt <= CW'(HOLD - 1);
        else if (dec && cnt != '0)   cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/decoder_3x8_pulse.sv
// Registered N-to-2**N decoder: holds the one-hot line HOLD cycles, then one recovery cycle.
// Define DECODER_HIST_EN to add the sticky hist output and hist_clr input.
module decoder_3x8_pulse
    import dec_pkg::*;
#(
    parameter int N    = DEC_N,
    parameter int HOLD = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            in_valid,
    input  logic [N-1:0]    in_code,
    output logic            in_ready,
    output logic [2**N-1:0] out,
    output logic            out_valid,
    output logic            done
`ifdef DECODER_HIST_EN
    ,
    input  logic            hist_clr,
    output logic [2**N-1:0] hist
`endif
);

    if (N < 1 || N > DEC_NMAX) begin : g_bad_n
        $error("decoder_3x8_pulse: N must be 1..4");
    end
    if (HOLD < 1) begin : g_bad_hold
        $error("decoder_3x8_pulse: HOLD must be >= 1");
    end

    dec_state_e state, state_nxt;
    logic [2**N-1:0] out_nxt;
    logic            ov_nxt, done_nxt;
    logic            cnt_load, cnt_dec, cnt_clr, cnt_zero;
    logic            xfer;

    logic [2**DEC_NMAX-1:0] oh_full;
    logic [2**N-1:0]        oh;
    logic                   unused_oh;

    assign in_ready  = en && (state == IDLE);
    assign xfer      = in_valid && in_ready;
    assign oh_full   = onehot(DEC_NMAX'(in_code));
    assign oh        = oh_full[2**N-1:0];
    assign unused_oh = ^oh_full;

    hold_counter #(.HOLD(HOLD)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load),
        .dec  (cnt_dec),
        .clr  (cnt_clr),
        .zero (cnt_zero)
    );

    always_comb begin
        state_nxt = state;
        out_nxt   = out;
        ov_nxt    = out_valid;
        done_nxt  = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        cnt_clr   = 1'b0;
        case (state)
            IDLE: begin
                if (xfer) begin
                    state_nxt = ACTIVE;
                    out_nxt   = oh;
                    ov_nxt    = 1'b1;
                    cnt_load  = 1'b1;
                end
            end
            ACTIVE: begin
                // Losing enable aborts the pulse silently, even on its last cycle.
                if (!en) begin
                    state_nxt = IDLE;
                    out_nxt   = '0;
                    ov_nxt    = 1'b0;
                    cnt_clr   = 1'b1;
                end else if (cnt_zero) begin
                    state_nxt = RECOVER;
                    out_nxt   = '0;
                    ov_nxt    = 1'b0;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            RECOVER: state_nxt = IDLE;
            default: begin
                state_nxt = IDLE;
                out_nxt   = '0;
                ov_nxt    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            out       <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            out       <= out_nxt;
            out_valid <= ov_nxt;
            done      <= done_nxt;
        end
    end

`ifdef DECODER_HIST_EN
    // Clear takes priority over the old history but not over a same-edge transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  hist <= '0;
        else if (hist_clr || xfer) hist <= (hist_clr ? '0 : hist) | (xfer ? oh : '0);
    end
`endif

endmodule

// File: tb/tb_decoder_3x8_pulse.sv
// Bench for decoder_3x8_pulse: HOLD=4 and HOLD=1 instances share stimulus, checked against a timeline model.
module tb_decoder_3x8_pulse;

    logic       clk, rst, en, in_valid, hist_clr;
    logic [2:0] in_code;
    logic       rdy_w [2];
    logic [7:0] out_w [2];
    logic       ov_w  [2];
    logic       done_w[2];
`ifdef DECODER_HIST_EN
    logic [7:0] hist_w[2];
`endif

    int n_asrt = 0;
    int n_fail = 0;

    // Model: cycle count, time of last accepted code per instance, abort/idle flag.
    int         cyc = 0;
    int         hold_of[2] = '{4, 1};
    int         t_x[2];
    logic [2:0] mcode[2];
    bit         ab[2];
    logic [7:0] mhist[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    decoder_3x8_pulse #(.N(3), .HOLD(4)) u0 (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_code(in_code),
        .in_ready(rdy_w[0]), .out(out_w[0]), .out_valid(ov_w[0]), .done(done_w[0])
`ifdef DECODER_HIST_EN
        , .hist_clr(hist_clr), .hist(hist_w[0])
`endif
    );

    decoder_3x8_pulse #(.N(3), .HOLD(1)) u1 (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_code(in_code),
        .in_ready(rdy_w[1]), .out(out_w[1]), .out_valid(ov_w[1]), .done(done_w[1])
`ifdef DECODER_HIST_EN
        , .hist_clr(hist_clr), .hist(hist_w[1])
`endif
    );

    task automatic chk(input string tag, input int idx, input logic [7:0] got, input logic [7:0] exp);
        n_asrt++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s[%0d] @cyc %0d: observed %h expected %h", tag, idx, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            t_x[i]   = -1000;
            mcode[i] = '0;
            ab[i]    = 1'b1;
            mhist[i] = '0;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            int         k;
            logic [7:0] e_out;
            k     = cyc - t_x[i];
            e_out = (!ab[i] && k < hold_of[i]) ? (8'd1 << mcode[i]) : 8'd0;
            chk("out",       i, out_w[i], e_out);
            chk("out_valid", i, {7'd0, ov_w[i]},   {7'd0, e_out != 8'd0});
            chk("done",      i, {7'd0, done_w[i]}, {7'd0, !ab[i] && k == hold_of[i]});
            chk("in_ready",  i, {7'd0, rdy_w[i]},  {7'd0, en && (ab[i] || k > hold_of[i])});
`ifdef DECODER_HIST_EN
            chk("hist",      i, hist_w[i], mhist[i]);
`endif
        end
    endtask

    // One clock: work out phase from the timeline, apply the edge, then check 1 time unit later.
    task automatic tick();
        bit act[2];
        bit rdy[2];
        for (int i = 0; i < 2; i++) begin
            int k;
            k      = cyc - t_x[i];
            act[i] = !ab[i] && k < hold_of[i];
            rdy[i] = en && (ab[i] || k > hold_of[i]);
        end
        @(posedge clk);
        cyc++;
        if (rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (act[i] && !en) ab[i] = 1'b1;
                if (hist_clr) mhist[i] = '0;
                if (rdy[i] && in_valid) begin
                    t_x[i]   = cyc;
                    mcode[i] = in_code;
                    ab[i]    = 1'b0;
                    mhist[i] = mhist[i] | (8'd1 << in_code);
                end
            end
        end
        #1 check_all();
    endtask

    task automatic send(input logic [2:0] c, input int gap);
        in_code  = c;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (gap) tick();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; in_valid = 1'b0; in_code = '0; hist_clr = 1'b0;
        model_reset();
        #1 check_all();
        tick(); tick();
        rst = 1'b0;
        tick();
        en = 1'b1;
        tick();

        // basic decode of code 5, then HOLD=1 corner codes 0 and 7
        send(3'd5, 7);
        send(3'd0, 6);
        send(3'd7, 6);

        // back-pressure: valid held high, code 2 then 7 queued
        in_code = 3'd2; in_valid = 1'b1;
        tick();
        in_code = 3'd7;
        repeat (8) tick();
        in_valid = 1'b0;
        repeat (2) tick();

        // sweep all codes with valid held
        for (int c = 0; c < 8; c++) begin
            in_code  = 3'(c);
            in_valid = 1'b1;
            repeat (6) tick();
        end
        in_valid = 1'b0;
        repeat (2) tick();

        // abort after two active cycles
        send(3'd1, 2);
        en = 1'b0;
        repeat (3) tick();
        en = 1'b1;
        repeat (6) tick();

        // async reset mid-hold
        send(3'd5, 2);
        #2 rst = 1'b1;
        #1 model_reset();
        check_all();
        #1 rst = 1'b0;
        tick(); tick();

        // history: clear, accumulate 1,4,6, then clear together with a code-3 transfer
        hist_clr = 1'b1;
        tick();
        hist_clr = 1'b0;
        send(3'd1, 6);
        send(3'd4, 6);
        send(3'd6, 6);
        hist_clr = 1'b1;
        in_code = 3'd3; in_valid = 1'b1;
        tick();
        hist_clr = 1'b0; in_valid = 1'b0;
        repeat (6) tick();

        // random traffic
        repeat (400) begin
            en       = ($urandom_range(0, 9) != 0);
            in_valid = 1'($urandom_range(0, 1));
            in_code  = 3'($urandom_range(0, 7));
            hist_clr = ($urandom_range(0, 15) == 0);
            tick();
        end
        en = 1'b1; in_valid = 1'b0; hist_clr = 1'b0;
        repeat (8) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
